// File: rtl/ej32_pkg.sv
// Shared eJ32 types, opcode constants and the per-opcode phase table.
// Used by the decoder, the branching unit and the testbench.
package ej32_pkg;

   localparam int PH_W = 3;

   typedef logic [7:0] opcode_t;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } dc_state_t;

   localparam opcode_t OP_NOP           = 8'h00;
   localparam opcode_t OP_IFEQ          = 8'h99;
   localparam opcode_t OP_IF_ICMPLE     = 8'hA4;
   localparam opcode_t OP_GOTO          = 8'hA7;
   localparam opcode_t OP_JSR           = 8'hA8;
   localparam opcode_t OP_INVOKEVIRTUAL = 8'hB6;
   localparam opcode_t OP_INVOKEDYNAMIC = 8'hBA;
   localparam opcode_t OP_DONEXT        = 8'hCA;

   // Phases per opcode, 1..8.  if* and if_icmp* are contiguous
   // (0x99..0xA4).
   function automatic logic [PH_W:0] op_len(input opcode_t op);
      logic [PH_W:0] n;
      n = (PH_W+1)'(1);
      unique case (1'b1)
         (op >= OP_IFEQ && op <= OP_IF_ICMPLE),
         (op == OP_GOTO),
         (op == OP_INVOKEVIRTUAL),
         (op == OP_DONEXT):
            n = (PH_W+1)'(2);
         (op == OP_JSR):
            n = (PH_W+1)'(3);
         default:
            n = (PH_W+1)'(1);
      endcase
      return n;
   endfunction

   // Low for invokedynamic and any opcode above donext.
   function automatic logic op_valid(input opcode_t op);
      return !((op == OP_INVOKEDYNAMIC) || (op > OP_DONEXT));
   endfunction

endpackage

// File: rtl/ej32_dc.sv
// eJ32 instruction decode / phase sequencer.
// Ports: clk, rst (sync, high), dc_en, data[7:0], hold, br_jmp in;
//        code_o[7:0], phase_o, last_o, bubble_o, err_o out.
module ej32_dc
   import ej32_pkg::*;
#(
   parameter int PH_SZ = PH_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dc_en,
   input  logic [7:0]       data,
   input  logic             hold,
   input  logic             br_jmp,
   output logic [7:0]       code_o,
   output logic [PH_SZ-1:0] phase_o,
   output logic             last_o,
   output logic             bubble_o,
   output logic             err_o
);

   dc_state_t        state_q, state_d;
   opcode_t          code_q, code_d;
   logic [PH_SZ-1:0] phase_q, phase_d;
   logic             err_q, err_d;
   logic             bubble_q, bubble_d;
   logic             go;
   logic             jump;
   logic             issue;
   logic [PH_W:0]    len;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RST;
      else     state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q   <= OP_NOP;
         phase_q  <= '0;
         err_q    <= 1'b0;
         bubble_q <= 1'b1;
      end else begin
         code_q   <= code_d;
         phase_q  <= phase_d;
         err_q    <= err_d;
         bubble_q <= bubble_d;
      end
   end

   // Next state; hold outranks br_jmp
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RST:     if (dc_en) state_d = FETCH;
         FETCH:   if (go) state_d = EXEC;
         EXEC:    if (jump) state_d = FETCH;
         default: state_d = RST;
      endcase
   end

   // Outputs; last_o depends on registered state only
   always_comb begin
      len      = op_len(code_q);
      last_o   = (state_q == EXEC) &&
                 (phase_q == PH_SZ'(len - 1'b1));
      code_o   = code_q;
      phase_o  = phase_q;
      bubble_o = bubble_q;
      err_o    = err_q;
   end

   // Code / phase / error update
   always_comb begin
      go     = dc_en && !hold;
      jump   = go && (state_q == EXEC) && br_jmp;
      issue  = go && ((state_q == FETCH) ||
               ((state_q == EXEC) && last_o && !br_jmp));
      code_d   = code_q;
      phase_d  = phase_q;
      err_d    = err_q;
      bubble_d = (state_d != EXEC);
      if (jump) begin
         // bubble cycle reads as nop
         code_d  = OP_NOP;
         phase_d = '0;
      end else if (issue) begin
         // unsupported opcodes run as a 1-phase nop
         code_d  = op_valid(data) ? data : OP_NOP;
         phase_d = '0;
         err_d   = err_q | !op_valid(data);
      end else if (go && (state_q == EXEC)) begin
         phase_d = phase_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_ej32_dc.sv
// Scoreboard bench for ej32_dc: directed stimulus pushes expected
// outputs, a monitor pops and compares one entry per cycle.
module tb_ej32_dc;
   import ej32_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dc_en = 1'b1;
   logic [7:0] data = 8'h00;
   logic       hold = 1'b0;
   logic       br_jmp = 1'b0;
   logic [7:0] code_o;
   logic [2:0] phase_o;
   logic       last_o;
   logic       bubble_o;
   logic       err_o;

   always #5 clk = ~clk;

   ej32_dc dut (
      .clk      (clk),
      .rst      (rst),
      .dc_en    (dc_en),
      .data     (data),
      .hold     (hold),
      .br_jmp   (br_jmp),
      .code_o   (code_o),
      .phase_o  (phase_o),
      .last_o   (last_o),
      .bubble_o (bubble_o),
      .err_o    (err_o)
   );

   logic [13:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [13:0] act, e;
   string       n;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         act = {code_o, phase_o, last_o, bubble_o, err_o};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got code=%02h ph=%0d last=%b bub=%b err=%b, expected code=%02h ph=%0d last=%b bub=%b err=%b",
                     n, act[13:6], act[5:3], act[2], act[1], act[0],
                     e[13:6], e[5:3], e[2], e[1], e[0]);
         end
      end
   end

   task automatic cyc(input string nm, input logic r, input logic en,
                      input logic h, input logic j, input logic [7:0] d,
                      input logic [7:0] ec, input int ep,
                      input logic el, input logic eb, input logic ee);
      @(negedge clk);
      rst = r; dc_en = en; hold = h; br_jmp = j; data = d;
      @(posedge clk);
      exp_q.push_back({ec, 3'(ep), el, eb, ee});
      name_q.push_back(nm);
   endtask

   initial begin
      //   name        rst en hld jmp data   code ph last bub err
      cyc("reset0",    1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
      cyc("reset1",    1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
      cyc("rst2fetch", 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
      cyc("fetch_nop", 0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
      // back-to-back ifeq
      cyc("ifeq_p0",   0, 1, 0, 0, 8'h99, 8'h99, 0, 0, 0, 0);
      cyc("ifeq_p1",   0, 1, 0, 0, 8'h05, 8'h99, 1, 1, 0, 0);
      cyc("b2b_nop",   0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
      // goto redirect at phase 1
      cyc("goto_p0",   0, 1, 0, 0, 8'hA7, 8'hA7, 0, 0, 0, 0);
      cyc("goto_p1",   0, 1, 0, 0, 8'h11, 8'hA7, 1, 1, 0, 0);
      cyc("goto_jmp",  0, 1, 0, 1, 8'h22, 8'h00, 0, 0, 1, 0);
      cyc("goto_tgt",  0, 1, 0, 0, 8'h60, 8'h60, 0, 1, 0, 0);
      // jsr redirect at phase 2
      cyc("jsr_p0",    0, 1, 0, 0, 8'hA8, 8'hA8, 0, 0, 0, 0);
      cyc("jsr_p1",    0, 1, 0, 0, 8'h00, 8'hA8, 1, 0, 0, 0);
      cyc("jsr_p2",    0, 1, 0, 0, 8'h10, 8'hA8, 2, 1, 0, 0);
      cyc("jsr_jmp",   0, 1, 0, 1, 8'h33, 8'h00, 0, 0, 1, 0);
      cyc("jsr_tgt",   0, 1, 0, 0, 8'h03, 8'h03, 0, 1, 0, 0);
      // hold during invokevirtual phase 0, jump ignored
      cyc("inv_p0",    0, 1, 0, 0, 8'hB6, 8'hB6, 0, 0, 0, 0);
      cyc("hold0",     0, 1, 1, 0, 8'h44, 8'hB6, 0, 0, 0, 0);
      cyc("hold_jmp",  0, 1, 1, 1, 8'h44, 8'hB6, 0, 0, 0, 0);
      cyc("hold2",     0, 1, 1, 0, 8'h44, 8'hB6, 0, 0, 0, 0);
      cyc("inv_p1",    0, 1, 0, 0, 8'h44, 8'hB6, 1, 1, 0, 0);
      cyc("inv_next",  0, 1, 0, 0, 8'h04, 8'h04, 0, 1, 0, 0);
      // unsupported opcode
      cyc("bad_op",    0, 1, 0, 0, 8'hBA, 8'h00, 0, 1, 0, 1);
      cyc("after_p0",  0, 1, 0, 0, 8'h99, 8'h99, 0, 0, 0, 1);
      cyc("after_p1",  0, 1, 0, 0, 8'h07, 8'h99, 1, 1, 0, 1);
      cyc("after_nxt", 0, 1, 0, 0, 8'h05, 8'h05, 0, 1, 0, 1);
      // disabled: full freeze
      cyc("dis0",      0, 0, 0, 0, 8'hA7, 8'h05, 0, 1, 0, 1);
      cyc("dis_jmp",   0, 0, 0, 1, 8'hA7, 8'h05, 0, 1, 0, 1);
      // reset mid-instruction
      cyc("jsr2_p0",   0, 1, 0, 0, 8'hA8, 8'hA8, 0, 0, 0, 1);
      cyc("jsr2_p1",   0, 1, 0, 0, 8'h00, 8'hA8, 1, 0, 0, 1);
      cyc("mid_rst",   1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
      // jump at last phase wins over issue
      cyc("re_fetch",  0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
      cyc("re_ifeq",   0, 1, 0, 0, 8'h99, 8'h99, 0, 0, 0, 0);
      cyc("re_p1",     0, 1, 0, 0, 8'h05, 8'h99, 1, 1, 0, 0);
      cyc("last_jmp",  0, 1, 0, 1, 8'h60, 8'h00, 0, 0, 1, 0);
      cyc("last_tgt",  0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
